mem2_load_align: RTL and testbench
==================================

// Module: mem2_load_align
// PURPOSE
//  Second memory stage, directly downstream of mem1 and consuming its registered output.
//  Waits for the DCache read response of the load issued by mem1.
//  Aligns and sign/zero-extends the returned word, then merges it with non-load results.
//  Feeds the mem2->wb pipeline register and the dispatch/EX forwarding path.
//  Owns the stall logic for outstanding loads and discards stale responses after a flush.
// PARAMETERS
//  DATA_WIDTH  32  GPR/DCache data width
//  ADDR_WIDTH  32  PC width
// PORTS
//  clk             in   1   clock (single clock domain)
//  rst             in   1   reset, asynchronous, active-low
//  flush           in   1   pipeline flush (exception/redirect)
//  clear           in   1   insert bubble into output register
//  advance         in   1   pipeline advance
//  advance_ready   out  1   stage can advance this cycle
//  m1_valid        in   1   instruction valid
//  m1_pc           in   32  instruction PC
//  m1_excp         in   1   instruction carries exception
//  m1_load         in   1   load issued to DCache (LD.*, LL)
//  m1_ld_type      in   3   000 B, 001 BU, 010 H, 011 HU, 100 W/LL
//  m1_addr_lo      in   2   paddr[1:0] of the access
//  m1_wreg         in   1   writes GPR
//  m1_waddr        in   5   destination GPR
//  m1_wdata        in   32  non-load result
//  dcache_rvalid_i in   1   one-cycle pulse; dcache_rdata_i valid
//  dcache_rdata_i  in   32  raw aligned word from DCache
//  fwd_wreg        out  1   forward: writes GPR
//  fwd_valid       out  1   forward: fwd_wdata final
//  fwd_waddr       out  5   forward: destination
//  fwd_wdata       out  32  forward: result
//  wb_valid, wb_pc[32], wb_excp, wb_wreg, wb_waddr[5], wb_wdata[32]  out  registered to WB
// BEHAVIOUR
//  - Reset: all wb_* outputs 0. FSM returns to IDLE and data_hold_vld is cleared.
//  - need_data = m1_valid & m1_load & ~m1_excp.
//  - FSM states IDLE, WAIT, DRAIN.
//    - IDLE -> WAIT when need_data & ~dcache_rvalid_i.
//    - WAIT -> IDLE on dcache_rvalid_i; data is captured into data_hold and data_hold_vld is set.
//    - WAIT -> DRAIN on flush without dcache_rvalid_i.
//    - DRAIN: the next dcache_rvalid_i pulse is discarded, then -> IDLE. Responses are in order.
//  - Stall: advance_ready = ~need_data | dcache_rvalid_i | data_hold_vld.
//    - advance_ready is forced 0 in DRAIN while a new load is present.
//  - Data selection: ld_raw = dcache_rvalid_i ? dcache_rdata_i : data_hold.
//  - Alignment: sh = ld_raw >> (8*m1_addr_lo). Extension by m1_ld_type:
//    - B: {{24{sh[7]}}, sh[7:0]}
//    - BU: {24'b0, sh[7:0]}
//    - H: {{16{sh[15]}}, sh[15:0]}
//    - HU: {16'b0, sh[15:0]}
//    - W: ld_raw
//  - result = need_data ? aligned : m1_wdata.
//  - data_hold_vld clears on advance or flush. A pulse in the same cycle as advance is consumed, not held.
//  - Output register: flush|clear -> all wb_* 0; else on advance -> wb_* <= {m1_*, result}. Latency 1.
//  - m1_excp: no wait, advance_ready=1, wb_wreg forced 0.
//  - Simultaneous flush & dcache_rvalid_i in WAIT: the pulse is dropped and the FSM goes to IDLE (not DRAIN).
//  - Reset mid-WAIT: FSM -> IDLE. The DCache is reset in the same domain.
// CONFIGURATION
//  MEM2_LOAD_FWD_EN defined:
//    fwd_valid = ~need_data | dcache_rvalid_i | data_hold_vld.
//    fwd_wdata carries the aligned load data in the cycle the data is available.
//  MEM2_LOAD_FWD_EN undefined:
//    fwd_valid = ~need_data. Consumers stall until WB.
//  fwd_wreg, fwd_waddr and fwd_wdata are identical in both builds.
// TESTING
//  T1 LD.B addr_lo=2, rvalid same cycle with rdata=0x12_80_34_56, advance=1
//     -> wb_wdata=0xFFFFFF80 next cycle.
//  T2 LD.HU addr_lo=2, rdata=0x8001_0000, rvalid 3 cycles after issue
//     -> advance_ready=0 for 3 cycles, then wb_wdata=0x00008001.
//  T3 LD.W, rvalid with advance=0 held 2 more cycles
//     -> data_hold returns 0xDEADBEEF when advance rises; no loss.
//  T4 Flush in WAIT, new LD.W follows, stale rvalid (0x1111) then rvalid (0x2222)
//     -> 0x1111 discarded; wb_wdata=0x2222.
//  T5 m1_excp=1 with m1_load=1
//     -> advance_ready=1 immediately, wb_excp=1, wb_wreg=0.
//  T6 MEM2_LOAD_FWD_EN on/off, LD.BU waiting
//     -> fwd_valid rises with rvalid when defined; stays 0 until advance when undefined.

Source files
------------

// File: rtl/mem2_load_align.sv
// mem2_load_align: second memory stage.
// Waits for the DCache response of the load issued in mem1, aligns and
// sign/zero-extends it, merges it with non-load results, and registers the
// outcome towards WB. Responses that belong to a flushed load are drained
// and discarded.
// Optional build macro: MEM2_LOAD_FWD_EN (forward load data as soon as it
// arrives instead of only non-load results).
module mem2_load_align #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clear,
    input  logic                  advance,
    output logic                  advance_ready,
    input  logic                  m1_valid,
    input  logic [ADDR_WIDTH-1:0] m1_pc,
    input  logic                  m1_excp,
    input  logic                  m1_load,
    input  logic [2:0]            m1_ld_type,
    input  logic [1:0]            m1_addr_lo,
    input  logic                  m1_wreg,
    input  logic [4:0]            m1_waddr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  dcache_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dcache_rdata_i,
    output logic                  fwd_wreg,
    output logic                  fwd_valid,
    output logic [4:0]            fwd_waddr,
    output logic [DATA_WIDTH-1:0] fwd_wdata,
    output logic                  wb_valid,
    output logic [ADDR_WIDTH-1:0] wb_pc,
    output logic                  wb_excp,
    output logic                  wb_wreg,
    output logic [4:0]            wb_waddr,
    output logic [DATA_WIDTH-1:0] wb_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic                    hold_vld_q;
    logic                    hold_vld_d;
    logic [DATA_WIDTH-1:0]   data_hold_q;
    logic [DATA_WIDTH-1:0]   data_hold_d;

    logic                    need_data_s;
    logic                    rsp_use_s;
    logic [DATA_WIDTH-1:0]   ld_raw_s;
    logic [DATA_WIDTH-1:0]   sh_s;
    logic [DATA_WIDTH-1:0]   aligned_s;
    logic [DATA_WIDTH-1:0]   result_s;

    // A load that really needs data from the DCache (exceptions never wait).
    assign need_data_s = m1_valid & m1_load & ~m1_excp;

    // A response arriving in DRAIN belongs to a flushed load and is ignored.
    assign rsp_use_s   = dcache_rvalid_i & (state_q != ST_DRAIN);

    assign ld_raw_s    = rsp_use_s ? dcache_rdata_i : data_hold_q;
    assign sh_s        = ld_raw_s >> {m1_addr_lo, 3'b000};

    // Extend the shifted word according to the load type.
    always_comb begin
        aligned_s = ld_raw_s;
        case (m1_ld_type)
            3'b000:  aligned_s = {{(DATA_WIDTH-8){sh_s[7]}}, sh_s[7:0]};
            3'b001:  aligned_s = {{(DATA_WIDTH-8){1'b0}}, sh_s[7:0]};
            3'b010:  aligned_s = {{(DATA_WIDTH-16){sh_s[15]}}, sh_s[15:0]};
            3'b011:  aligned_s = {{(DATA_WIDTH-16){1'b0}}, sh_s[15:0]};
            3'b100:  aligned_s = ld_raw_s;
            default: aligned_s = ld_raw_s;
        endcase
    end

    assign result_s      = need_data_s ? aligned_s : m1_wdata;

    // Stalls only while a needed load has neither a usable pulse nor held data.
    assign advance_ready = ~need_data_s | rsp_use_s | hold_vld_q;

    assign fwd_wreg      = m1_valid & m1_wreg & ~m1_excp;
    assign fwd_waddr     = m1_waddr;
    assign fwd_wdata     = result_s;
`ifdef MEM2_LOAD_FWD_EN
    assign fwd_valid     = ~need_data_s | rsp_use_s | hold_vld_q;
`else
    assign fwd_valid     = ~need_data_s;
`endif

    // Next-state logic for the outstanding-load tracker.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (need_data_s & ~dcache_rvalid_i & ~hold_vld_q) begin
                    // A load flushed before its response must still be drained.
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dcache_rvalid_i) begin
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (dcache_rvalid_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold a response that arrives while the stage cannot advance.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        data_hold_d = data_hold_q;
        if (flush | advance) begin
            hold_vld_d = 1'b0;
        end else if (rsp_use_s & need_data_s) begin
            hold_vld_d  = 1'b1;
            data_hold_d = dcache_rdata_i;
        end else begin
            hold_vld_d  = hold_vld_q;
        end
    end

    // FSM state and load-data hold registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hold_vld_q  <= 1'b0;
            data_hold_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            hold_vld_q  <= hold_vld_d;
            data_hold_q <= data_hold_d;
        end
    end

    // mem2->wb pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_pc    <= {ADDR_WIDTH{1'b0}};
            wb_excp  <= 1'b0;
            wb_wreg  <= 1'b0;
            wb_waddr <= 5'd0;
            wb_wdata <= {DATA_WIDTH{1'b0}};
        end else if (flush | clear) begin
            wb_valid <= 1'b0;
            wb_pc    <= {ADDR_WIDTH{1'b0}};
            wb_excp  <= 1'b0;
            wb_wreg  <= 1'b0;
            wb_waddr <= 5'd0;
            wb_wdata <= {DATA_WIDTH{1'b0}};
        end else if (advance) begin
            wb_valid <= m1_valid;
            wb_pc    <= m1_pc;
            wb_excp  <= m1_excp;
            wb_wreg  <= m1_wreg & ~m1_excp;
            wb_waddr <= m1_waddr;
            wb_wdata <= result_s;
        end else begin
            wb_valid <= wb_valid;
            wb_pc    <= wb_pc;
            wb_excp  <= wb_excp;
            wb_wreg  <= wb_wreg;
            wb_waddr <= wb_waddr;
            wb_wdata <= wb_wdata;
        end
    end

endmodule

// File: tb/tb_mem2_load_align.sv
// Scoreboard bench for mem2_load_align: a DCache model answers loads in order
// after a random delay; expected WB records are queued on every accepted
// advance and a separate monitor pops and compares them.
module tb_mem2_load_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, clear, advance, advance_ready;
    logic        m1_valid, m1_excp, m1_load, m1_wreg;
    logic [31:0] m1_pc, m1_wdata;
    logic [2:0]  m1_ld_type;
    logic [1:0]  m1_addr_lo;
    logic [4:0]  m1_waddr;
    logic        dcache_rvalid_i;
    logic [31:0] dcache_rdata_i;
    logic        fwd_wreg, fwd_valid;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_wdata;
    logic        wb_valid, wb_excp, wb_wreg;
    logic [31:0] wb_pc, wb_wdata;
    logic [4:0]  wb_waddr;

    always #5 clk = ~clk;

    mem2_load_align dut (
        .clk(clk), .rst(rst_n), .flush(flush), .clear(clear), .advance(advance),
        .advance_ready(advance_ready), .m1_valid(m1_valid), .m1_pc(m1_pc),
        .m1_excp(m1_excp), .m1_load(m1_load), .m1_ld_type(m1_ld_type),
        .m1_addr_lo(m1_addr_lo), .m1_wreg(m1_wreg), .m1_waddr(m1_waddr),
        .m1_wdata(m1_wdata), .dcache_rvalid_i(dcache_rvalid_i),
        .dcache_rdata_i(dcache_rdata_i), .fwd_wreg(fwd_wreg), .fwd_valid(fwd_valid),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_excp(wb_excp), .wb_wreg(wb_wreg), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        excp;
        logic        load;
        logic [2:0]  ty;
        logic [1:0]  lo;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] word;
    } instr_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        excp;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    wb_t  exp_q[$];
    rsp_t dc_q[$];
    int   cyc = 0;
    int   stale_cnt = 0;
    int   last_due = -1;
    int   checks = 0;
    int   errors = 0;

    // Load result from the architectural rule: pick the addressed byte/half
    // arithmetically and extend it.
    function automatic logic [31:0] ref_load(input logic [2:0] ty, input logic [1:0] lo,
                                             input logic [31:0] w);
        longint s;
        longint v;
        s = longint'(w) / (longint'(1) << (8 * int'(lo)));
        case (ty)
            3'd0: begin v = s % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: v = s % 256;
            3'd2: begin v = s % 65536; if (v >= 32768) v = v - 65536; end
            3'd3: v = s % 65536;
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        m1_valid = 1'b0; m1_pc = 32'd0; m1_excp = 1'b0; m1_load = 1'b0;
        m1_ld_type = 3'd0; m1_addr_lo = 2'd0; m1_wreg = 1'b0; m1_waddr = 5'd0;
        m1_wdata = 32'd0; flush = 1'b0; clear = 1'b0; advance = 1'b0;
        dcache_rvalid_i = 1'b0; dcache_rdata_i = 32'd0;
    endtask

    // Present one instruction until it advances or is flushed.
    // adv_wait < 0 selects random advance/clear behaviour.
    task automatic do_instr(input instr_t t, input int d, input int flush_at, input int adv_wait);
        logic        need, got, rdy, fl, cl, adv;
        logic [31:0] res;
        int          rdy_cnt, stale_before, due;
        bit          done;
        wb_t         e;
        need    = t.valid & t.load & ~t.excp;
        got     = 1'b0;
        rdy_cnt = 0;
        done    = 1'b0;
        res     = need ? ref_load(t.ty, t.lo, t.word) : t.wdata;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (k == 0 && need) begin
                due = cyc + d;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                dc_q.push_back('{due, t.word});
            end
            m1_valid = t.valid; m1_pc = t.pc; m1_excp = t.excp; m1_load = t.load;
            m1_ld_type = t.ty; m1_addr_lo = t.lo; m1_wreg = t.wreg;
            m1_waddr = t.waddr; m1_wdata = t.wdata;
            stale_before = stale_cnt;
            if (dc_q.size() > 0 && dc_q[0].due <= cyc) begin
                dcache_rvalid_i = 1'b1;
                dcache_rdata_i  = dc_q[0].data;
                void'(dc_q.pop_front());
                if (stale_cnt > 0) stale_cnt--;
                else               got = 1'b1;
            end else begin
                dcache_rvalid_i = 1'b0;
                dcache_rdata_i  = $urandom;
            end
            rdy = ~need | got;
            fl  = (k == flush_at) && (stale_before == 0);
            if (fl && need && !got) stale_cnt++;
            cl  = !fl && adv_wait < 0 && ($urandom_range(0, 15) == 0);
            if (adv_wait < 0) adv = !fl && !cl && rdy && ($urandom_range(0, 3) != 0);
            else              adv = !fl && !cl && rdy && (rdy_cnt >= adv_wait);
            if (rdy) rdy_cnt++;
            flush = fl; clear = cl; advance = adv;
            if (adv) begin
                e.valid = t.valid; e.pc = t.pc; e.excp = t.excp;
                e.wreg  = t.wreg & ~t.excp; e.waddr = t.waddr; e.wdata = res;
                exp_q.push_back(e);
            end
            #1;
            chk("advance_ready", {31'd0, advance_ready}, {31'd0, rdy});
`ifdef MEM2_LOAD_FWD_EN
            chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, rdy});
`else
            chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, ~need});
`endif
            chk("fwd_wreg", {31'd0, fwd_wreg}, {31'd0, t.valid & t.wreg & ~t.excp});
            chk("fwd_waddr", {27'd0, fwd_waddr}, {27'd0, t.waddr});
            if (rdy) chk("fwd_wdata", fwd_wdata, res);
            if (fl || adv) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: instr pc %h never advanced", t.pc);
        end
    endtask

    function automatic instr_t mk(input logic ld, input logic ex, input logic [2:0] ty,
                                  input logic [1:0] lo, input logic [31:0] word);
        instr_t t;
        t.valid = 1'b1; t.pc = $urandom; t.excp = ex; t.load = ld; t.ty = ty; t.lo = lo;
        t.wreg = 1'b1; t.waddr = 5'($urandom_range(1, 31)); t.wdata = $urandom; t.word = word;
        return t;
    endfunction

    // Monitor: compares the WB register after every edge that updated it.
    initial begin
        logic ev_adv, ev_zero;
        wb_t  e;
        forever begin
            @(posedge clk);
            ev_adv  = rst_n & advance & ~flush & ~clear;
            ev_zero = rst_n & (flush | clear);
            #2;
            if (ev_zero) begin
                chk("wb_valid_bubble", {31'd0, wb_valid}, 32'd0);
                chk("wb_wdata_bubble", wb_wdata, 32'd0);
            end else if (ev_adv) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got pc %h expected no output", wb_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.valid});
                    chk("wb_pc", wb_pc, e.pc);
                    chk("wb_excp", {31'd0, wb_excp}, {31'd0, e.excp});
                    chk("wb_wreg", {31'd0, wb_wreg}, {31'd0, e.wreg});
                    chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, e.waddr});
                    chk("wb_wdata", wb_wdata, e.wdata);
                end
            end
        end
    end

    initial begin
        instr_t t;
        drive_idle();
        rst_n = 1'b0;
        #12;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_advance_ready", {31'd0, advance_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // LD.B at byte 2, same-cycle response -> 0xFFFFFF80.
        do_instr(mk(1'b1, 1'b0, 3'd0, 2'd2, 32'h1280_3456), 0, -1, 0);
        // LD.HU at byte 2, response 3 cycles late -> 0x00008001.
        do_instr(mk(1'b1, 1'b0, 3'd3, 2'd2, 32'h8001_0000), 3, -1, 0);
        // LD.W held in the data buffer for two cycles.
        do_instr(mk(1'b1, 1'b0, 3'd4, 2'd0, 32'hDEAD_BEEF), 1, -1, 2);
        // Flush while waiting, then a new load: the stale 0x1111 is dropped.
        do_instr(mk(1'b1, 1'b0, 3'd4, 2'd0, 32'h0000_1111), 4, 1, 0);
        do_instr(mk(1'b1, 1'b0, 3'd4, 2'd0, 32'h0000_2222), 0, -1, 0);
        // Load carrying an exception: no wait, no GPR write.
        do_instr(mk(1'b1, 1'b1, 3'd4, 2'd0, 32'h5555_AAAA), 2, -1, 0);
        // LD.BU waiting on the DCache.
        do_instr(mk(1'b1, 1'b0, 3'd1, 2'd3, 32'hC300_0000), 2, -1, 1);

        for (int n = 0; n < 400; n++) begin
            t = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), $urandom);
            t.valid = ($urandom_range(0, 7) != 0);
            t.wreg  = 1'($urandom_range(0, 1));
            do_instr(t, $urandom_range(0, 4),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1, -1);
        end

        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
